// File: rtl/bootcopy_pkg.sv
// Shared state encoding, default parameters and address helper for the boot copy engine.
package bootcopy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_GAP,
    ST_FINISH
  } state_e;

  localparam int         MAX_RETRY_DEF = 3;
  localparam int         TIMEOUT_DEF   = 255;
  localparam logic [3:0] SEL_WORD      = 4'hf;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bootcopy_wbm.sv
// Single-access Wishbone classic master: drives the bus while act is high and
// classifies each cycle's response into ack / retry / abort (err, retry overflow, timeout).
module bootcopy_wbm
  import bootcopy_pkg::*;
#(
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        act,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        acc_ack,
  output logic        acc_retry,
  output logic        acc_abort,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] wait_cnt;
  logic          resp_err, resp_ack, resp_rty, no_resp, retry_over, timed_out;

  // err > ack > rty when several responses arrive together
  assign resp_err   = act & wb_err_i;
  assign resp_ack   = act & wb_ack_i & ~wb_err_i;
  assign resp_rty   = act & wb_rty_i & ~wb_err_i & ~wb_ack_i;
  assign no_resp    = act & ~wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign retry_over = resp_rty & (retry_cnt == RW'(MAX_RETRY));
  assign timed_out  = (TIMEOUT != 0) & no_resp & (wait_cnt == TW'(TIMEOUT - 1));

  assign acc_ack   = resp_ack;
  assign acc_retry = resp_rty & ~retry_over;
  assign acc_abort = resp_err | retry_over | timed_out;

  // Retry budget is per word: it survives the read ack and is refunded on the write ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       retry_cnt <= '0;
    else if (clr || (resp_ack && we)) retry_cnt <= '0;
    else if (resp_rty)              retry_cnt <= retry_cnt + RW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         wait_cnt <= '0;
    else if (no_resp) wait_cnt <= wait_cnt + TW'(1);
    else              wait_cnt <= '0;
  end

  assign wb_cyc_o = act;
  assign wb_stb_o = act;
  assign wb_we_o  = act & we;
  assign wb_sel_o = act ? SEL_WORD : 4'h0;
  assign wb_adr_o = act ? adr : 32'h0;
  assign wb_dat_o = (act && we) ? dat : 32'h0;

endmodule

// File: rtl/bootcopy.sv
// Boot copy engine: word-by-word read/write sequencer moving len words from src to dst
// over a Wishbone classic bus, with retry, timeout and error abort.
module bootcopy
  import bootcopy_pkg::*;
#(
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_adr,
  input  logic [31:0] dst_adr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  state_e      state, state_nxt;
  logic [31:0] src_q, dst_q, data_q;
  logic [15:0] cnt_q;
  logic        gap_we_q, error_q;
  logic        act, we, acc_ack, acc_retry, acc_abort;

  assign act = (state == ST_READ) || (state == ST_WRITE);
  assign we  = (state == ST_WRITE);

  bootcopy_wbm #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) u_wbm (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == ST_IDLE),
    .act      (act),
    .we       (we),
    .adr      (we ? dst_q : src_q),
    .dat      (data_q),
    .acc_ack  (acc_ack),
    .acc_retry(acc_retry),
    .acc_abort(acc_abort),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (len != 16'd0) ? ST_READ : ST_FINISH;
      ST_READ, ST_WRITE: begin
        if (acc_abort)      state_nxt = ST_FINISH;
        else if (acc_ack)   state_nxt = (state == ST_READ) ? ST_WRITE :
                                        (cnt_q == 16'd1)   ? ST_FINISH : ST_READ;
        else if (acc_retry) state_nxt = ST_GAP;
      end
      ST_GAP:    state_nxt = gap_we_q ? ST_WRITE : ST_READ;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      gap_we_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        error_q <= 1'b0;
        if (len != 16'd0) begin
          src_q <= word_align(src_adr);
          dst_q <= word_align(dst_adr);
          cnt_q <= len;
        end
      end
      if (acc_abort) error_q <= 1'b1;
      if (acc_ack && state == ST_READ) data_q <= wb_dat_i;
      if (acc_ack && state == ST_WRITE) begin
        src_q <= src_q + 32'd4;
        dst_q <= dst_q + 32'd4;
        cnt_q <= cnt_q - 16'd1;
      end
      // remember which access to reissue once the gap cycle is over
      if (acc_retry) gap_we_q <= we;
    end
  end

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_FINISH);
  assign error = error_q;

endmodule

// File: tb/tb_bootcopy.sv
// Randomized self-checking bench for bootcopy: scripted Wishbone slave with fault
// injection, plus a transaction-level model of the expected copy outcome.
module tb_bootcopy;
  localparam int MAX_R = 3;
  localparam int TMO   = 8;
  localparam int NONE  = 1 << 30;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] src_adr = '0, dst_adr = '0;
  logic [15:0] len = '0;
  logic        busy, done, error;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  int checks = 0, errors = 0;

  bootcopy #(.MAX_RETRY(MAX_R), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .src_adr(src_adr), .dst_adr(dst_adr), .len(len),
    .busy(busy), .done(done), .error(error),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE5A17;
  endfunction

  // slave plan and observation
  int lat = 1, err_at = NONE, rty_at = NONE, rty_n = 0;
  bit silent = 0, multi = 0;
  int acc_idx = 0, rty_given = 0, gap_chk = 0, wcnt = 0, stb_cycles = 0;
  bit new_acc = 1;
  logic [31:0] gap_adr;
  logic [31:0] obs_adr[$], obs_dat[$];
  bit          obs_we[$];

  task automatic set_plan(input int l, input bit sil, input int ea, input int ra, input int rn, input bit m);
    lat = l; silent = sil; err_at = ea; rty_at = ra; rty_n = rn; multi = m;
    acc_idx = 0; rty_given = 0; gap_chk = 0; stb_cycles = 0;
    obs_adr.delete(); obs_dat.delete(); obs_we.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = '0;
      if (gap_chk == 2) begin
        chk("reissue_stb", 32'(wb_stb_o), 32'd1);
        chk("reissue_adr", wb_adr_o, gap_adr);
        gap_chk = 0;
      end
      if (gap_chk == 1) begin
        chk("gap_cyc", 32'(wb_cyc_o), 32'd0);
        gap_chk = 2;
      end
      if (wb_stb_o) begin
        stb_cycles++;
        if (new_acc) wcnt = 0; else wcnt++;
        new_acc = 0;
        if (!silent && wcnt >= lat) begin
          new_acc = 1;
          if (acc_idx == err_at) begin
            wb_err_i = 1;
            if (multi) begin wb_ack_i = 1; wb_rty_i = 1; end
          end else if (acc_idx == rty_at && rty_given < rty_n) begin
            wb_rty_i = 1;
            rty_given++;
            if (rty_given <= MAX_R) begin gap_chk = 1; gap_adr = wb_adr_o; end
          end else begin
            wb_ack_i = 1;
            if (multi) wb_rty_i = 1;
            if (!wb_we_o) wb_dat_i = rom(wb_adr_o);
            chk("sel", 32'(wb_sel_o), 32'hf);
            obs_adr.push_back(wb_adr_o);
            obs_we.push_back(wb_we_o);
            obs_dat.push_back(wb_dat_o);
            acc_idx++;
          end
        end
      end else new_acc = 1;
    end
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input bit poke);
    logic [31:0] ea[$], ed[$];
    bit          ew[$];
    logic [31:0] rs, ws;
    int stop, busy_cyc, done_at, done_cnt, nchk;
    bit eerr, seen;
    // expected transaction list and abort point
    for (int i = 0; i < int'(n); i++) begin
      rs = {s[31:2], 2'b00} + 32'(4 * i);
      ws = {d[31:2], 2'b00} + 32'(4 * i);
      ea.push_back(rs); ew.push_back(1'b0); ed.push_back(32'h0);
      ea.push_back(ws); ew.push_back(1'b1); ed.push_back(rom(rs));
    end
    stop = 2 * int'(n); eerr = 0;
    if (n != 0 && silent) begin stop = 0; eerr = 1; end
    if (err_at < stop) begin stop = err_at; eerr = 1; end
    if (rty_at < stop && rty_n > MAX_R) begin stop = rty_at; eerr = 1; end

    busy_cyc = 0; done_at = -1; done_cnt = 0; seen = 0;
    @(negedge clk);
    src_adr = s; dst_adr = d; len = n; start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_on", 32'(busy), 32'd1);
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) start = 0;
      if (seen && !done) break;
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; if (!seen) done_at = k; seen = 1; end
      if (poke && k == 1 && busy && n >= 2) begin start = 1; len = 16'd0; end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("busy_off", 32'(busy), 32'd0);
    chk("error", 32'(error), 32'(eerr));
    chk("n_acc", 32'(obs_adr.size()), 32'(stop));
    nchk = (obs_adr.size() < stop) ? obs_adr.size() : stop;
    for (int i = 0; i < nchk; i++) begin
      chk("acc_adr", obs_adr[i], ea[i]);
      chk("acc_we", 32'(obs_we[i]), 32'(ew[i]));
      if (ew[i]) chk("wr_dat", obs_dat[i], ed[i]);
    end
    if (n != 0 && silent) chk("wait_cycles", 32'(stb_cycles), 32'(TMO));
    if (n == 0) begin
      chk("empty_done_at", 32'(done_at), 32'd0);
      chk("empty_busy", 32'(busy_cyc), 32'd1);
      chk("empty_stb", 32'(stb_cycles), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done, m, nn;
    bit reached;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    @(negedge clk); rst = 1;

    set_plan(1, 0, NONE, NONE, 0, 0); run_copy(32'h0, 32'h1000, 16'd4, 0);        // nominal
    set_plan(1, 0, NONE, NONE, 0, 0); run_copy(32'h40, 32'h80, 16'd0, 0);         // empty
    set_plan(1, 0, NONE, 2, 2, 0);    run_copy(32'h0, 32'h1000, 16'd4, 0);        // rty x2 on 2nd read
    set_plan(1, 0, 1, NONE, 0, 0);    run_copy(32'h0, 32'h1000, 16'd4, 0);        // err on first write
    set_plan(1, 1, NONE, NONE, 0, 0); run_copy(32'h100, 32'h200, 16'd2, 0);       // silent slave
    set_plan(0, 0, NONE, NONE, 0, 0); run_copy(32'hFFFFFFF8, 32'h2003, 16'd3, 0); // wrap
    set_plan(1, 0, NONE, 3, MAX_R + 1, 0); run_copy(32'h10, 32'h20, 16'd3, 0);   // retry overflow
    set_plan(0, 0, 3, NONE, 0, 1);    run_copy(32'h500, 32'h600, 16'd4, 0);       // simultaneous responses
    set_plan(2, 0, NONE, NONE, 0, 0); run_copy(32'h0, 32'h1000, 16'd1, 0);        // error cleared by new start

    // reset during the third access
    set_plan(1, 0, NONE, NONE, 0, 0);
    @(negedge clk); src_adr = 32'h0; dst_adr = 32'h1000; len = 16'd4; start = 1;
    @(negedge clk); start = 0;
    reached = 0;
    for (int k = 0; k < 200 && !reached; k++) begin
      if (acc_idx >= 2 && wb_stb_o) reached = 1; else @(negedge clk);
    end
    chk("reach_third", 32'(reached), 32'd1);
    #1 rst = 0;
    #1;
    chk("arst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_adr", wb_adr_o, 32'd0);
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1;
      if (done) seen_done++;
    end
    chk("arst_no_done", 32'(seen_done), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);

    // randomized copies
    for (int r = 0; r < 12; r++) begin
      m = $urandom_range(0, 3);
      nn = $urandom_range(1, 6);
      case (m)
        0: set_plan($urandom_range(0, 2), 0, NONE, NONE, 0, 0);
        1: set_plan($urandom_range(0, 2), 0, NONE, $urandom_range(0, 2 * nn - 1), $urandom_range(1, MAX_R + 1), 0);
        2: set_plan($urandom_range(0, 2), 0, NONE, NONE, 0, 1);
        default: set_plan($urandom_range(0, 2), 0, $urandom_range(0, 2 * nn - 1), NONE, 0, $urandom_range(0, 1));
      endcase
      run_copy($urandom, $urandom, 16'(nn), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
